float_addsub_pipe: RTL and testbench
====================================

// Module: float_addsub_pipe
// PURPOSE
//  Pipelined, parametrised IEEE-754-style floating-point adder/subtractor.
//  Successor to the combinational float adder, adding:
//  - a per-operation add/sub select
//  - round-to-nearest-even (RNE) rounding
//  - inf/NaN handling and exception flags
//  - a 3-stage valid/ready pipeline
//  Sits between operand-issue logic and the result writeback in the FP datapath.
// PARAMETERS
//  EXP_WIDTH    5                      exponent field width; bias = 2^(EXP_WIDTH-1)-1
//  MAN_WIDTH    10                     stored mantissa width; hidden bit implied
//  FLOAT_WIDTH  1+EXP_WIDTH+MAN_WIDTH  derived; do not override
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous reset, active-high
//  in_valid   in   1            operand pair valid
//  in_ready   out  1            block can accept operands this cycle
//  float_a    in   FLOAT_WIDTH  operand A
//  float_b    in   FLOAT_WIDTH  operand B
//  op_sub     in   1            0: A+B, 1: A-B (B sign inverted at stage 1)
//  out_valid  out  1            result valid
//  out_ready  in   1            downstream accepts result
//  res        out  FLOAT_WIDTH  rounded result
//  flags      out  4            {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  - Reset (async): all stage valids, out_valid, res and flags -> 0 immediately.
//    Operations in flight are discarded. in_ready = 1 in the first cycle after reset release.
//  - Advance enable: adv = ~out_valid | out_ready.
//    - in_ready = adv. A transfer occurs when in_valid & in_ready.
//    - When adv=0 every stage holds; no data is lost or duplicated (bubbles do not collapse).
//  - Latency: 3 cycles from accept to out_valid with out_ready held high.
//    Throughput: 1 op/cycle.
//  - S1 (unpack/align):
//    - classify each operand: zero (exp=0; subnormals flushed to zero), inf, NaN
//    - apply op_sub to the B sign
//    - swap so the larger magnitude is first
//    - right-shift the smaller significand by the exponent difference into
//      MAN_WIDTH+1 bits plus guard, round and sticky bits
//    - a shift >= MAN_WIDTH+3 leaves only sticky (sticky=1 if the operand is nonzero)
//  - S2 (add/normalise):
//    - add on effective-add, subtract on effective-sub; the result is always >= 0 after the swap
//    - carry-out: shift right 1, exp+1, old LSB ORed into sticky
//    - otherwise: leading-zero count, shift left, exponent decremented by the count
//  - S3 (round/pack):
//    - RNE: increment if G & (R | S | LSB)
//    - mantissa overflow from rounding: exp+1
//    - pack the result and set flags
//  - Result sign:
//    - the larger-magnitude operand's sign
//    - exact cancellation (x - x) -> +0
//    - (+0)+(+0) = +0, (-0)+(-0) = -0, mixed-sign zeros -> +0
//  - Special cases (override the arithmetic):
//    - any NaN operand -> canonical qNaN {0, all-ones exp, 1 then zeros}
//    - inf - inf (effective) -> qNaN with invalid=1
//    - inf op finite -> inf with that inf's sign
//    - zero op X -> X with the applied sign
//  - Overflow: exp >= all-ones after rounding -> signed inf, overflow=1, inexact=1.
//  - Underflow: normalised exp <= 0 -> signed zero, underflow=1, inexact=1 (flush-to-zero).
//  - inexact=1 whenever any G/R/S bit is nonzero before rounding.
//  - res/flags are stable while out_valid & ~out_ready.
// TESTING
//  - 0x3C00 + 0x3C00 (op_sub=0) -> res 0x4000, flags 0, out_valid exactly 3 cycles after accept
//  - 0x4200 - 0x3C00 (op_sub=1) -> 0x4000; 0x3C00 - 0x3C00 -> 0x0000, flags 0
//  - RNE ties:
//    - 0x3C00 + 0x1000 -> 0x3C00, inexact=1
//    - 0x3C01 + 0x1000 -> 0x3C02, inexact=1
//  - Exceptions:
//    - 0x7BFF + 0x7BFF -> 0x7C00, flags 0101
//    - 0x7C00 + 0xFC00 -> 0x7E00, flags 1000
//    - 0x7E00 + 0x3C00 -> 0x7E00
//  - Back-to-back stream of 8 ops with out_ready toggled 1,0,0,1... -> results in issue order,
//    none dropped or repeated; in_ready low exactly when out_valid & ~out_ready
//  - Assert rst mid-stream with 3 ops in flight -> out_valid/res/flags 0 asynchronously;
//    no stale result emerges after release

Source files
------------

// File: rtl/float_addsub_pipe.sv
// Three-stage floating-point adder/subtractor with round-to-nearest-even and IEEE-style flags.
// Stages: unpack/align, add/normalise, round/pack. A single advance enable stalls the whole pipe.
module float_addsub_pipe #(
    parameter int EXP_WIDTH   = 5,
    parameter int MAN_WIDTH   = 10,
    parameter int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] float_a,
    input  logic [FLOAT_WIDTH-1:0] float_b,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] res,
    output logic [3:0]             flags
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends combinationally on the same-side valid.
    localparam int SW = MAN_WIDTH + 1;          // significand with hidden bit
    localparam int AW = SW + 3;                 // significand plus guard, round, sticky
    localparam int WW = SW + MAN_WIDTH + 2;     // alignment shifter width
    localparam int XW = EXP_WIDTH + 2;          // exponent with headroom and sign
    localparam int LW = $clog2(AW + 1);
    localparam logic [EXP_WIDTH-1:0]   EXP_MAX   = '1;
    localparam logic [EXP_WIDTH-1:0]   SHIFT_LIM = EXP_WIDTH'(MAN_WIDTH + 3);
    localparam logic [FLOAT_WIDTH-1:0] QNAN      = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

    function automatic logic [LW-1:0] count_lz(input logic [AW-1:0] v);
        logic [LW-1:0] n;
        n = LW'(AW);
        for (int i = 0; i < AW; i++) begin
            if (v[i]) n = LW'(AW - 1 - i);
        end
        return n;
    endfunction

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- Stage 1: classify, swap, align ----------------
    logic                 sa, sb;
    logic [EXP_WIDTH-1:0] ea, eb, big_exp, small_exp, shift;
    logic [MAN_WIDTH-1:0] ma, mb, big_man, small_man;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big, big_sign;
    logic [SW-1:0]        small_sig;
    logic [WW-1:0]        wide;
    logic [AW-1:0]        aligned;
    logic                 special;
    logic [FLOAT_WIDTH-1:0] spec_res;
    logic [3:0]           spec_flags;

    assign sa = float_a[FLOAT_WIDTH-1];
    assign ea = float_a[FLOAT_WIDTH-2:MAN_WIDTH];
    assign ma = float_a[MAN_WIDTH-1:0];
    assign sb = float_b[FLOAT_WIDTH-1] ^ op_sub;
    assign eb = float_b[FLOAT_WIDTH-2:MAN_WIDTH];
    assign mb = float_b[MAN_WIDTH-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_MAX) && (ma == '0);
    assign b_inf  = (eb == EXP_MAX) && (mb == '0);
    assign a_nan  = (ea == EXP_MAX) && (ma != '0);
    assign b_nan  = (eb == EXP_MAX) && (mb != '0);

    always_comb begin
        a_big     = {ea, ma} >= {eb, mb};
        big_sign  = a_big ? sa : sb;
        big_exp   = a_big ? ea : eb;
        big_man   = a_big ? ma : mb;
        small_exp = a_big ? eb : ea;
        small_man = a_big ? mb : ma;
        shift     = big_exp - small_exp;
        small_sig = {1'b1, small_man};
        wide      = {small_sig, {(MAN_WIDTH+2){1'b0}}} >> shift;
        // Far-shifted operands survive only as sticky; the hidden bit makes them nonzero.
        if (shift >= SHIFT_LIM) aligned = {{(SW+2){1'b0}}, 1'b1};
        else                    aligned = {wide[WW-1 -: SW+2], |wide[MAN_WIDTH-1:0]};
    end

    always_comb begin
        special    = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (a_inf) begin
            spec_res = {sa, EXP_MAX, {MAN_WIDTH{1'b0}}};
        end else if (b_inf) begin
            spec_res = {sb, EXP_MAX, {MAN_WIDTH{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_res = {sa & sb, {(FLOAT_WIDTH-1){1'b0}}};
        end else if (a_zero) begin
            spec_res = {sb, eb, mb};
        end else if (b_zero) begin
            spec_res = float_a;
        end else begin
            special = 1'b0;
        end
    end

    logic                   s1_valid, s1_special, s1_sign, s1_sub;
    logic [FLOAT_WIDTH-1:0] s1_spec_res;
    logic [3:0]             s1_spec_flags;
    logic [EXP_WIDTH-1:0]   s1_exp;
    logic [SW-1:0]          s1_big_sig;
    logic [AW-1:0]          s1_small;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_special    <= 1'b0;
            s1_sign       <= 1'b0;
            s1_sub        <= 1'b0;
            s1_spec_res   <= '0;
            s1_spec_flags <= '0;
            s1_exp        <= '0;
            s1_big_sig    <= '0;
            s1_small      <= '0;
        end else if (adv) begin
            s1_valid      <= in_valid;
            s1_special    <= special;
            s1_sign       <= big_sign;
            s1_sub        <= sa ^ sb;
            s1_spec_res   <= spec_res;
            s1_spec_flags <= spec_flags;
            s1_exp        <= big_exp;
            s1_big_sig    <= {1'b1, big_man};
            s1_small      <= aligned;
        end
    end

    // ---------------- Stage 2: add/subtract and normalise ----------------
    logic [AW:0]          sum;
    logic [LW-1:0]        lz;
    logic [AW-1:0]        norm;
    logic [MAN_WIDTH-1:0] n_man;
    logic [2:0]           n_grs;
    logic [XW-1:0]        n_exp;
    logic                 n_zero;

    always_comb begin
        if (s1_sub) sum = {1'b0, s1_big_sig, 3'b000} - {1'b0, s1_small};
        else        sum = {1'b0, s1_big_sig, 3'b000} + {1'b0, s1_small};
        lz   = count_lz(sum[AW-1:0]);
        norm = sum[AW-1:0] << lz;
        if (sum[AW]) begin
            n_man = sum[AW-1:4];
            n_grs = {sum[3], sum[2], |sum[1:0]};
            n_exp = {2'b00, s1_exp} + XW'(1);
        end else begin
            n_man = norm[AW-2:3];
            n_grs = norm[2:0];
            n_exp = {2'b00, s1_exp} - {{(XW-LW){1'b0}}, lz};
        end
        // Without a carry, a nonzero sum always normalises to a leading one.
        n_zero = ~sum[AW] & ~norm[AW-1];
    end

    logic                   s2_valid, s2_special, s2_sign, s2_zero;
    logic [FLOAT_WIDTH-1:0] s2_spec_res;
    logic [3:0]             s2_spec_flags;
    logic [XW-1:0]          s2_exp;
    logic [MAN_WIDTH-1:0]   s2_man;
    logic [2:0]             s2_grs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            s2_special    <= 1'b0;
            s2_sign       <= 1'b0;
            s2_zero       <= 1'b0;
            s2_spec_res   <= '0;
            s2_spec_flags <= '0;
            s2_exp        <= '0;
            s2_man        <= '0;
            s2_grs        <= '0;
        end else if (adv) begin
            s2_valid      <= s1_valid;
            s2_special    <= s1_special;
            s2_sign       <= s1_sign;
            s2_zero       <= n_zero;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_exp        <= n_exp;
            s2_man        <= n_man;
            s2_grs        <= n_grs;
        end
    end

    // ---------------- Stage 3: round and pack ----------------
    logic                   round_up, inexact, uflow, oflow;
    logic [MAN_WIDTH:0]     m_plus;
    logic [XW-1:0]          exp_r;
    logic [FLOAT_WIDTH-1:0] res_n;
    logic [3:0]             flags_n;

    always_comb begin
        round_up = s2_grs[2] & (s2_grs[1] | s2_grs[0] | s2_man[0]);
        inexact  = |s2_grs;
        m_plus   = {1'b0, s2_man} + {{MAN_WIDTH{1'b0}}, round_up};
        exp_r    = s2_exp + {{(XW-1){1'b0}}, m_plus[MAN_WIDTH]};
        uflow    = s2_exp[XW-1] | (s2_exp == '0);
        oflow    = exp_r >= {2'b00, EXP_MAX};
        if (s2_special) begin
            res_n   = s2_spec_res;
            flags_n = s2_spec_flags;
        end else if (s2_zero) begin
            res_n   = '0;
            flags_n = '0;
        end else if (uflow) begin
            res_n   = {s2_sign, {(FLOAT_WIDTH-1){1'b0}}};
            flags_n = 4'b0011;
        end else if (oflow) begin
            res_n   = {s2_sign, EXP_MAX, {MAN_WIDTH{1'b0}}};
            flags_n = 4'b0101;
        end else begin
            res_n   = {s2_sign, exp_r[EXP_WIDTH-1:0], m_plus[MAN_WIDTH-1:0]};
            flags_n = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= '0;
            flags     <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            res       <= res_n;
            flags     <= flags_n;
        end
    end
endmodule

// File: tb/tb_float_addsub_pipe.sv
// Directed bench for float_addsub_pipe: expected results queue up at issue and are
// checked in order as the pipeline delivers them, including stalls and mid-stream reset.
module tb_float_addsub_pipe;
    logic        clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [15:0] float_a, float_b, res;
    logic [3:0]  flags;

    logic [19:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          out_id   = 0;
    logic        pat_mode = 1'b0;

    float_addsub_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .float_a(float_a), .float_b(float_b), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .flags(flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream sink: always ready, or the 1,0,0 repeating pattern.
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (pat_mode) begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                out_ready = 1'b1;
                ph = 0;
            end
        end
    end

    // Output monitor, sampled mid-cycle after the sink has settled.
    initial begin
        logic        held;
        logic [20:0] held_v;
        logic [19:0] e;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 1'b0;
            end else begin
                checks++;
                assert (in_ready === (~out_valid | out_ready)) else begin
                    failures++;
                    $error("FAIL in_ready got=%b expected=%b", in_ready, ~out_valid | out_ready);
                end
                if (held) begin
                    checks++;
                    assert ({out_valid, res, flags} === held_v) else begin
                        failures++;
                        $error("FAIL stall_hold got=%h expected=%h", {out_valid, res, flags}, held_v);
                    end
                end
                held   = out_valid & ~out_ready;
                held_v = {out_valid, res, flags};
                if (out_valid && out_ready) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        failures++;
                        $error("FAIL unexpected_output got=%h expected=none", {res, flags});
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        assert ({res, flags} === e) else begin
                            failures++;
                            $error("FAIL result_op%0d got=%h/%b expected=%h/%b",
                                   out_id, res, flags, e[19:4], e[3:0]);
                        end
                        out_id++;
                    end
                end
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 after the operand was taken.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] r, input logic [3:0] f);
        int n;
        float_a  = a;
        float_b  = b;
        op_sub   = sub;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            failures++;
            $error("FAIL accept_timeout got=%b expected=1", in_ready);
        end
        exp_q.push_back({r, f});
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL drain got=%0d expected=0", exp_q.size());
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        in_valid = 1'b0;
        float_a = '0;
        float_b = '0;
        op_sub = 1'b0;
        #1;
        checks++;
        assert ({out_valid, res, flags} === 21'h0) else begin
            failures++;
            $error("FAIL reset_state got=%h expected=0", {out_valid, res, flags});
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        checks++;
        assert (in_ready === 1'b1) else begin
            failures++;
            $error("FAIL ready_after_reset got=%b expected=1", in_ready);
        end

        // Latency: one op, out_valid on the third rising edge after acceptance.
        float_a = 16'h3C00; float_b = 16'h3C00; op_sub = 1'b0; in_valid = 1'b1;
        exp_q.push_back({16'h4000, 4'b0000});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        assert (cyc === 3) else begin
            failures++;
            $error("FAIL latency got=%0d expected=3", cyc);
        end
        drain();

        // Directed operations, issued back to back with the sink always ready.
        send(16'h4200, 16'h3C00, 1'b1, 16'h4000, 4'b0000);
        send(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
        send(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001);
        send(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001);
        send(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
        send(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000);
        send(16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000);
        send(16'h3C00, 16'h7C01, 1'b0, 16'h7E00, 4'b0000);
        send(16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 4'b0000);
        send(16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 4'b0000);
        send(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000);
        send(16'h0000, 16'h3C00, 1'b1, 16'hBC00, 4'b0000);
        send(16'h0000, 16'h8000, 1'b0, 16'h0000, 4'b0000);
        send(16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000);
        send(16'h0401, 16'h0400, 1'b1, 16'h0000, 4'b0011);
        send(16'hBC00, 16'hBC00, 1'b1, 16'h0000, 4'b0000);
        send(16'h3C00, 16'h0001, 1'b0, 16'h3C00, 4'b0000);
        send(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 4'b0001);
        drain();

        // Back-to-back stream while the sink stalls two cycles out of three.
        pat_mode = 1'b1;
        send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
        send(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000);
        send(16'h4200, 16'h3C00, 1'b1, 16'h4000, 4'b0000);
        send(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
        send(16'h4400, 16'h4000, 1'b1, 16'h4000, 4'b0000);
        send(16'hBC00, 16'hBC00, 1'b0, 16'hC000, 4'b0000);
        send(16'h3C00, 16'h0000, 1'b0, 16'h3C00, 4'b0000);
        send(16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000);
        drain();
        pat_mode = 1'b0;
        @(negedge clk);
        #1;

        // Reset with three operations in flight.
        send(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
        send(16'h4000, 16'h3C00, 1'b0, 16'h4200, 4'b0000);
        send(16'h4400, 16'h4000, 1'b1, 16'h4000, 4'b0000);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        assert ({out_valid, res, flags} === 21'h0) else begin
            failures++;
            $error("FAIL async_reset got=%h expected=0", {out_valid, res, flags});
        end
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        checks++;
        assert (in_ready === 1'b1 && out_valid === 1'b0) else begin
            failures++;
            $error("FAIL release got=%b%b expected=10", in_ready, out_valid);
        end
        repeat (8) @(negedge clk);
        #1;
        send(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
